final_tcp_hw_nios2_cpu_div_cell: RTL and testbench
==================================================

Name: final_tcp_hw_nios2_cpu_div_cell

Overview:
- Iterative integer divider for the Nios II execute datapath; it is the inverse-operation companion to the multiply cell.
- Accepts a 32-bit dividend/divisor pair with a one-cycle start pulse, runs one restoring radix-2 step per clock, and returns quotient and remainder with a one-cycle done pulse.
- Serves the div/divu instructions; the pipeline holds the instruction in E/M while busy is high.

Parameters:
- DIV_WIDTH, 32, operand/result width; latency scales as DIV_WIDTH+3.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- E_src1  in  DIV_WIDTH  dividend
- E_src2  in  DIV_WIDTH  divisor
- E_div_start  in  1  start request; sampled only in IDLE
- E_div_signed  in  1  1 = signed (div), 0 = unsigned (divu); sampled with start
- E_div_kill  in  1  abort in-flight operation (pipeline flush)
- M_div_busy  out  1  high from the cycle after accepted start until done
- M_div_done  out  1  one-cycle pulse, results valid
- M_div_quot  out  DIV_WIDTH  quotient
- M_div_rem  out  DIV_WIDTH  remainder
- M_div_zero  out  1  divisor was zero for the last completed op

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, quot=0, rem=0, div_zero=0; iteration counter=0.
- States: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
- IDLE: on start=1, latch operands, signed flag, and raw signs; go to PREP. start=0 stays IDLE.
- PREP (1 cycle):
  - Form magnitudes: if signed and operand MSB=1, two's-complement negate, else pass.
  - Clear partial remainder (DIV_WIDTH+1 bits); load quotient shift reg with |dividend|; counter=DIV_WIDTH-1; capture div_zero = (divisor==0).
- ITER (DIV_WIDTH cycles), each cycle:
  - Shift {rem,quot} left 1; trial = rem - |divisor|.
  - If trial >= 0: rem=trial, quot LSB=1; else quot LSB=0.
  - At counter==0 go to FIX, else decrement.
- FIX (1 cycle):
  - If signed and dividend sign != divisor sign and divisor != 0: negate quotient.
  - If signed and dividend negative: negate remainder. Truncation toward zero; remainder takes dividend sign.
- DONE (1 cycle): done=1; quot/rem/div_zero update at DONE entry and hold until next accepted start completes; return to IDLE.
- busy=1 in PREP, ITER, FIX; 0 in IDLE and DONE.
- Latency: start sampled at edge 0 -> done high in cycle DIV_WIDTH+3 (35 for 32-bit). Fixed; independent of operand values.
- Back-to-back: start may be asserted in the DONE cycle but is ignored. Next acceptance is the IDLE cycle after DONE. Minimum issue interval is DIV_WIDTH+4.
- start while busy: ignored, no queuing.
- Divide by zero: no special path.
  - Unsigned: quot=all ones, rem=dividend.
  - Signed: quotient not negated; rem = dividend (sign-restored).
  - div_zero=1. Full latency still applies.
- Signed overflow: 0x80000000 / -1 gives quot=0x80000000, rem=0 (natural wrap), no flag.
- Kill:
  - E_div_kill=1 in PREP/ITER/FIX forces IDLE next cycle. No done pulse; quot/rem/div_zero keep prior values.
  - Kill in IDLE or DONE has no effect; done in DONE still pulses.
  - Kill and start together in IDLE: start is accepted.
- Reset mid-operation: immediate return to IDLE with all outputs zero; no done.

Test Plan:
- Unsigned 100/7, start at edge 0 -> busy 1..34, done pulse at cycle 35 only, quot=14, rem=2, div_zero=0.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> quot=0xFFFFFFFD, rem=0xFFFFFFFF. Signed 7/-2 -> quot=0xFFFFFFFD, rem=1.
- Unsigned 0x12345678/0 -> quot=0xFFFFFFFF, rem=0x12345678, div_zero=1 at cycle 35. Following 9/3 -> quot=3, rem=0, div_zero=0.
- Signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0. Unsigned 0xFFFFFFFF/1 -> quot=0xFFFFFFFF, rem=0.
- Start 50/5, re-pulse start with 9/4 at cycles 10 and 35 -> both ignored; done at 35 with quot=10, rem=0. Start at 36 accepted -> done at 71, quot=2, rem=1.
- Kill at cycle 20 of 50/5 -> busy low at 21, no done, prior results held. Async reset asserted mid-ITER -> outputs 0 immediately; after release, 8/3 completes in 35 cycles with quot=2, rem=2.

Source files
------------

// File: rtl/final_tcp_hw_nios2_cpu_div_cell.sv
// Iterative restoring radix-2 divider for div/divu: one quotient bit per clock.
// Results and the divide-by-zero flag are registered when DONE is entered and held until the next completed operation.
//
// state | meaning
// IDLE  | waiting for start; operands are latched on an accepted start
// PREP  | form operand magnitudes, clear partial remainder, load counter
// ITER  | one shift/trial-subtract step per cycle, DIV_WIDTH cycles
// FIX   | restore signs of quotient and remainder
// DONE  | one-cycle done pulse; start is ignored here
module final_tcp_hw_nios2_cpu_div_cell #(
   parameter int DIV_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] E_src1,
   input  logic [DIV_WIDTH-1:0] E_src2,
   input  logic                 E_div_start,
   input  logic                 E_div_signed,
   input  logic                 E_div_kill,
   output logic                 M_div_busy,
   output logic                 M_div_done,
   output logic [DIV_WIDTH-1:0] M_div_quot,
   output logic [DIV_WIDTH-1:0] M_div_rem,
   output logic                 M_div_zero
);

   localparam int CW = (DIV_WIDTH > 1) ? $clog2(DIV_WIDTH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q;
   logic [DIV_WIDTH-1:0] a_q, b_q, quo_q, dmag_q;
   logic [DIV_WIDTH:0]   rem_q;
   logic                 sgn_q, a_neg_q, b_neg_q, zero_q;
   logic [DIV_WIDTH-1:0] quot_out_q, rem_out_q;
   logic                 zero_out_q;

   logic [DIV_WIDTH-1:0] a_mag, b_mag, quo_sh, quot_fix, rem_fix;
   logic [DIV_WIDTH:0]   rem_sh, trial;
   logic                 ge;
   logic                 in_flight;

   assign in_flight = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (E_div_start) state_d = S_PREP;
         S_PREP:  state_d = S_ITER;
         S_ITER:  if (cnt_q == '0) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (E_div_kill && in_flight) state_d = S_IDLE;
   end

   always_comb begin
      M_div_busy = in_flight;
      M_div_done = (state_q == S_DONE);
   end

   assign a_mag = (sgn_q && a_q[DIV_WIDTH-1]) ? -a_q : a_q;
   assign b_mag = (sgn_q && b_q[DIV_WIDTH-1]) ? -b_q : b_q;

   assign rem_sh = {rem_q[DIV_WIDTH-1:0], quo_q[DIV_WIDTH-1]};
   assign quo_sh = {quo_q[DIV_WIDTH-2:0], 1'b0};
   assign ge     = (rem_sh >= {1'b0, dmag_q});
   assign trial  = rem_sh - {1'b0, dmag_q};

   // A zero divisor leaves the all-ones quotient un-negated; the remainder still takes the dividend sign.
   assign quot_fix = (sgn_q && (a_neg_q ^ b_neg_q) && !zero_q) ? -quo_q : quo_q;
   assign rem_fix  = (sgn_q && a_neg_q) ? -rem_q[DIV_WIDTH-1:0] : rem_q[DIV_WIDTH-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         quo_q      <= '0;
         dmag_q     <= '0;
         rem_q      <= '0;
         sgn_q      <= 1'b0;
         a_neg_q    <= 1'b0;
         b_neg_q    <= 1'b0;
         zero_q     <= 1'b0;
         quot_out_q <= '0;
         rem_out_q  <= '0;
         zero_out_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (E_div_start) begin
               a_q     <= E_src1;
               b_q     <= E_src2;
               sgn_q   <= E_div_signed;
               a_neg_q <= E_src1[DIV_WIDTH-1];
               b_neg_q <= E_src2[DIV_WIDTH-1];
            end
            S_PREP: begin
               rem_q  <= '0;
               quo_q  <= a_mag;
               dmag_q <= b_mag;
               cnt_q  <= CW'(DIV_WIDTH - 1);
               zero_q <= (b_q == '0);
            end
            S_ITER: begin
               rem_q <= ge ? trial : rem_sh;
               quo_q <= {quo_sh[DIV_WIDTH-1:1], ge};
               if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            end
            S_FIX: if (!E_div_kill) begin
               quot_out_q <= quot_fix;
               rem_out_q  <= rem_fix;
               zero_out_q <= zero_q;
            end
            default: ;
         endcase
      end
   end

   assign M_div_quot = quot_out_q;
   assign M_div_rem  = rem_out_q;
   assign M_div_zero = zero_out_q;

endmodule

// File: tb/tb_final_tcp_hw_nios2_cpu_div_cell.sv
// Directed bench for the iterative divider: latency, busy window, signed/unsigned results,
// divide by zero, overflow, ignored starts, kill and asynchronous reset.
module tb_final_tcp_hw_nios2_cpu_div_cell;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] E_src1, E_src2;
   logic        E_div_start, E_div_signed, E_div_kill;
   logic        M_div_busy, M_div_done, M_div_zero;
   logic [31:0] M_div_quot, M_div_rem;

   int n_chk  = 0;
   int n_pass = 0;

   final_tcp_hw_nios2_cpu_div_cell #(.DIV_WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .E_src1       (E_src1),
      .E_src2       (E_src2),
      .E_div_start  (E_div_start),
      .E_div_signed (E_div_signed),
      .E_div_kill   (E_div_kill),
      .M_div_busy   (M_div_busy),
      .M_div_done   (M_div_done),
      .M_div_quot   (M_div_quot),
      .M_div_rem    (M_div_rem),
      .M_div_zero   (M_div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
   endtask

   // Start at the edge after the current negedge (edge 0); cycle k is sampled at the negedge after edge k-1.
   task automatic run_op(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez);
      int          done_cyc = 0;
      int          n_done   = 0;
      int          busy_bad = 0;
      logic [31:0] q = '0, r = '0;
      logic        z = 1'b0;
      @(negedge clk);
      E_src1 = a; E_src2 = b; E_div_signed = sg; E_div_start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         E_div_start = 1'b0;
         if (M_div_busy !== ((k >= 1) && (k <= 34))) busy_bad++;
         if (M_div_done === 1'b1) begin
            n_done++;
            if (done_cyc == 0) begin
               done_cyc = k;
               q = M_div_quot; r = M_div_rem; z = M_div_zero;
            end
         end
      end
      chk({tag, " done_cycle"}, 32'(done_cyc), 32'd35);
      chk({tag, " done_count"}, 32'(n_done), 32'd1);
      chk({tag, " busy_window_errors"}, 32'(busy_bad), 32'd0);
      chk({tag, " quot"}, q, eq);
      chk({tag, " rem"}, r, er);
      chk({tag, " div_zero"}, 32'(z), 32'(ez));
   endtask

   initial begin
      int          n_done;
      logic [31:0] q35, r35, q71, r71;
      logic        b36, b37;

      reset = 1'b1;
      E_src1 = '0; E_src2 = '0;
      E_div_start = 1'b0; E_div_signed = 1'b0; E_div_kill = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset busy", 32'(M_div_busy), 32'd0);
      chk("reset done", 32'(M_div_done), 32'd0);
      chk("reset quot", M_div_quot, 32'd0);
      chk("reset rem",  M_div_rem,  32'd0);
      chk("reset zero", 32'(M_div_zero), 32'd0);
      reset = 1'b0;

      run_op("u100/7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
      run_op("s-7/2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
      run_op("s7/-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0);
      run_op("u/0",      1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1);
      run_op("u9/3",     1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0);
      run_op("s-9/0",    1'b1, 32'hFFFF_FFF7,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF7,  1'b1);
      run_op("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
      run_op("uFFFF/1",  1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0);

      // 50/5 with ignored re-starts at cycles 10 (busy) and 35 (DONE), accepted re-start at 36.
      n_done = 0; q35 = '0; r35 = '0; q71 = '0; r71 = '0; b36 = 1'b1; b37 = 1'b0;
      @(negedge clk);
      E_src1 = 32'd50; E_src2 = 32'd5; E_div_signed = 1'b0; E_div_start = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (M_div_done === 1'b1) n_done++;
         if (k == 35) begin q35 = M_div_quot; r35 = M_div_rem; end
         if (k == 71) begin q71 = M_div_quot; r71 = M_div_rem; end
         if (k == 36) b36 = M_div_busy;
         if (k == 37) b37 = M_div_busy;
         if (k == 10 || k == 35 || k == 36) begin
            E_src1 = 32'd9; E_src2 = 32'd4; E_div_start = 1'b1;
         end else begin
            E_div_start = 1'b0;
         end
      end
      chk("b2b quot@35", q35, 32'd10);
      chk("b2b rem@35",  r35, 32'd0);
      chk("b2b busy@36", 32'(b36), 32'd0);
      chk("b2b busy@37", 32'(b37), 32'd1);
      chk("b2b quot@71", q71, 32'd2);
      chk("b2b rem@71",  r71, 32'd1);
      chk("b2b done_count", 32'(n_done), 32'd2);

      // Kill at cycle 20 of 50/5; previous results 2 r1 must survive.
      n_done = 0; b36 = 1'b0; b37 = 1'b1;
      @(negedge clk);
      E_src1 = 32'd50; E_src2 = 32'd5; E_div_start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         E_div_start = 1'b0;
         if (M_div_done === 1'b1) n_done++;
         if (k == 20) b36 = M_div_busy;
         if (k == 21) b37 = M_div_busy;
         E_div_kill = (k == 20);
      end
      E_div_kill = 1'b0;
      chk("kill busy@20", 32'(b36), 32'd1);
      chk("kill busy@21", 32'(b37), 32'd0);
      chk("kill no_done", 32'(n_done), 32'd0);
      chk("kill quot_held", M_div_quot, 32'd2);
      chk("kill rem_held",  M_div_rem,  32'd1);

      // Asynchronous reset in the middle of ITER clears outputs without waiting for an edge.
      @(negedge clk);
      E_src1 = 32'd77; E_src2 = 32'd3; E_div_start = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         E_div_start = 1'b0;
      end
      #1 reset = 1'b1;
      #1;
      chk("arst busy", 32'(M_div_busy), 32'd0);
      chk("arst done", 32'(M_div_done), 32'd0);
      chk("arst quot", M_div_quot, 32'd0);
      chk("arst rem",  M_div_rem,  32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op("post_rst u8/3", 1'b0, 32'd8, 32'd3, 32'd2, 32'd2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
